// File: rtl/free_list.sv
// Circular free list of physical register numbers for rename.
// Pops feed dispatch; retire and squash recovery push back.
module free_list #(
  parameter int NUM_PR = 64,
  parameter int NUM_LR = 32,
  localparam int PR_W = $clog2(NUM_PR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            isDispatch,
  input  logic            RegDest,
  input  logic            hazard_stall,
  input  logic            recover,
  input  logic            retire,
  input  logic            RegDest_retire,
  input  logic [PR_W-1:0] PR_old_retire,
  input  logic            RegDest_ROB,
  input  logic [PR_W-1:0] PR_new_flush,
  output logic [PR_W-1:0] p_rd_new,
  output logic            empty,
  output logic [PR_W-1:0] free_cnt,
  output logic            overflow
);

  localparam int DEPTH = NUM_PR - NUM_LR;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PR_W-1:0] DEPTH_C = PR_W'(DEPTH);

  logic [PR_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PR_W-1:0]  count;
  logic             ovf_q;

  logic             pop;
  logic             push_r;
  logic             push_f;
  logic             acc_r;
  logic             acc_f;
  logic             drop;
  logic [PR_W-1:0]  cnt_ap;
  logic [PR_W-1:0]  cnt_ar;
  logic [PR_W-1:0]  count_n;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W-1:0] tail_n;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign free_cnt = count;
  assign p_rd_new = mem[head];
  assign overflow = ovf_q;

  // Pop gating, in-order push acceptance against capacity, and
  // write slots: retire value lands first, squash value after it.
  always_comb begin
    pop     = isDispatch & RegDest & ~hazard_stall
            & ~recover & ~empty;
    push_r  = retire & RegDest_retire;
    push_f  = recover & RegDest_ROB;
    cnt_ap  = count - PR_W'(pop);
    acc_r   = push_r & (cnt_ap < DEPTH_C);
    cnt_ar  = cnt_ap + PR_W'(acc_r);
    acc_f   = push_f & (cnt_ar < DEPTH_C);
    count_n = cnt_ar + PR_W'(acc_f);
    drop    = (push_r & ~acc_r) | (push_f & ~acc_f);
    tail_r  = acc_r ? ptr_inc(tail) : tail;
    tail_n  = acc_f ? ptr_inc(tail_r) : tail_r;
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= DEPTH_C;
      ovf_q <= 1'b0;
    end else begin
      if (pop) head <= ptr_inc(head);
      tail  <= tail_n;
      count <= count_n;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Entry storage; reset reloads every non-architectural register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= PR_W'(NUM_LR + i);
    end else begin
      if (acc_r) mem[tail] <= PR_old_retire;
      if (acc_f) mem[tail_r] <= PR_new_flush;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: stimulus queues expectations,
// a negedge monitor compares allocations and status snapshots.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       isDispatch;
  logic       RegDest;
  logic       hazard_stall;
  logic       recover;
  logic       retire;
  logic       RegDest_retire;
  logic [5:0] PR_old_retire;
  logic       RegDest_ROB;
  logic [5:0] PR_new_flush;
  logic [5:0] p_rd_new;
  logic       empty;
  logic [5:0] free_cnt;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [5:0] p;
    logic [5:0] cnt;
    logic       emp;
    logic       ovf;
  } st_t;

  logic [5:0] aq [$];
  st_t        sq [$];

  free_list dut (
    .clk(clk),
    .rst(rst),
    .isDispatch(isDispatch),
    .RegDest(RegDest),
    .hazard_stall(hazard_stall),
    .recover(recover),
    .retire(retire),
    .RegDest_retire(RegDest_retire),
    .PR_old_retire(PR_old_retire),
    .RegDest_ROB(RegDest_ROB),
    .PR_new_flush(PR_new_flush),
    .p_rd_new(p_rd_new),
    .empty(empty),
    .free_cnt(free_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Monitor: check every accepted allocation and queued snapshot.
  always @(negedge clk) begin
    if (!rst && isDispatch && RegDest && !hazard_stall
        && !recover && !empty) begin
      checks++;
      if (aq.size() == 0) begin
        errors++;
        $display("FAIL alloc unexpected pop got %0d", p_rd_new);
      end else begin
        logic [5:0] e;
        e = aq.pop_front();
        if (p_rd_new !== e) begin
          errors++;
          $display("FAIL alloc got %0d exp %0d", p_rd_new, e);
        end
      end
    end
    while (sq.size() > 0) begin
      st_t s;
      s = sq.pop_front();
      checks++;
      if (free_cnt !== s.cnt || empty !== s.emp
          || overflow !== s.ovf
          || (!s.emp && p_rd_new !== s.p)) begin
        errors++;
        $display("FAIL %s got p=%0d cnt=%0d emp=%0b ovf=%0b exp p=%0d cnt=%0d emp=%0b ovf=%0b",
                 s.nm, p_rd_new, free_cnt, empty, overflow,
                 s.p, s.cnt, s.emp, s.ovf);
      end
    end
  end

  task automatic clr();
    rst = 0; isDispatch = 0; RegDest = 0;
    hazard_stall = 0; recover = 0; retire = 0;
    RegDest_retire = 0; PR_old_retire = '0;
    RegDest_ROB = 0; PR_new_flush = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic st(input string nm, input int p, input int cnt,
                    input bit emp, input bit ovf);
    st_t s;
    s.nm = nm; s.p = 6'(p); s.cnt = 6'(cnt);
    s.emp = emp; s.ovf = ovf;
    sq.push_back(s);
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
  endtask

  task automatic pop(input int v);
    aq.push_back(6'(v));
    isDispatch = 1; RegDest = 1;
    tick();
  endtask

  task automatic push_ret(input int v);
    retire = 1; RegDest_retire = 1; PR_old_retire = 6'(v);
    tick();
  endtask

  initial begin
    clr();
    rst = 1;
    tick();
    do_reset();
    st("reset", 32, 32, 0, 0);
    tick();

    for (int i = 0; i < 32; i++) pop(32 + i);
    st("drained", 0, 0, 1, 0);
    tick();

    isDispatch = 1; RegDest = 1;
    tick();
    st("pop_empty", 0, 0, 1, 0);
    tick();

    for (int i = 0; i < 30; i++) push_ret(10 + i);
    st("push30", 10, 30, 0, 0);
    for (int i = 0; i < 30; i++) pop(10 + i);
    st("pop30", 0, 0, 1, 0);

    push_ret(5);
    st("push5", 5, 1, 0, 0);
    push_ret(9);
    st("push9_wrap", 5, 2, 0, 0);
    pop(5);
    st("pop5", 9, 1, 0, 0);
    pop(9);
    st("pop9_wrap", 0, 0, 1, 0);

    retire = 1; RegDest_retire = 1; PR_old_retire = 6'd7;
    recover = 1; RegDest_ROB = 1; PR_new_flush = 6'd40;
    isDispatch = 1; RegDest = 1;
    tick();
    st("dual_push", 7, 2, 0, 0);
    pop(7);
    pop(40);
    st("dual_drain", 0, 0, 1, 0);

    push_ret(21);
    st("push21", 21, 1, 0, 0);
    isDispatch = 1; RegDest = 1; hazard_stall = 1;
    tick();
    st("gate_stall", 21, 1, 0, 0);
    isDispatch = 1; RegDest = 1; recover = 1;
    tick();
    st("gate_recover", 21, 1, 0, 0);
    isDispatch = 1; RegDest = 0;
    tick();
    st("gate_nodest", 21, 1, 0, 0);
    pop(21);
    st("pop21", 0, 0, 1, 0);

    do_reset();
    st("reset2", 32, 32, 0, 0);
    aq.push_back(6'd32);
    isDispatch = 1; RegDest = 1;
    retire = 1; RegDest_retire = 1; PR_old_retire = 6'd50;
    tick();
    st("full_pop_push", 33, 32, 0, 0);
    push_ret(3);
    st("overflow_set", 33, 32, 0, 1);
    tick();
    st("overflow_sticky", 33, 32, 0, 1);
    for (int i = 0; i < 31; i++) pop(33 + i);
    st("tail_is_50", 50, 1, 0, 1);
    pop(50);
    st("drain_after_ovf", 0, 0, 1, 1);

    do_reset();
    st("reset3", 32, 32, 0, 0);
    for (int i = 0; i < 10; i++) pop(32 + i);
    push_ret(1);
    push_ret(2);
    st("mid_op", 42, 24, 0, 0);
    rst = 1; isDispatch = 1; RegDest = 1;
    retire = 1; RegDest_retire = 1; PR_old_retire = 6'd4;
    tick();
    st("mid_reset", 32, 32, 0, 0);
    tick();
    tick();

    checks++;
    if (aq.size() != 0 || sq.size() != 0) begin
      errors++;
      $display("FAIL leftover got alloc=%0d status=%0d exp 0",
               aq.size(), sq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/free_list.md
# free_list

Circular FIFO of free physical register numbers feeding the dispatch stage's rename map. It supplies the next free physical destination register `p_rd_new` and removes it when an instruction with a destination dispatches. It reclaims registers from two sources: the superseded mapping of a retiring instruction, and the new mapping of a ROB entry squashed during recovery. At reset it holds every physical register not covered by the identity architectural mapping (`NUM_LR`..`NUM_PR-1`).

## Interface
- `NUM_PR`, 64: number of physical registers; `PR_W = clog2(NUM_PR)` = 6.
- `NUM_LR`, 32: number of logical registers; `DEPTH = NUM_PR - NUM_LR` = 32; pointer width = clog2(`DEPTH`) = 5; count width = `PR_W`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `isDispatch` input 1: dispatch slot holds a valid instruction.
- `RegDest` input 1: the dispatching instruction writes a register.
- `hazard_stall` input 1: dispatch stalled this cycle.
- `recover` input 1: ROB recovery walk in progress.
- `retire` input 1: ROB head retires this cycle.
- `RegDest_retire` input 1: the retiring instruction had a destination.
- `PR_old_retire` input `PR_W`: superseded physical register of the retiring instruction.
- `RegDest_ROB` input 1: the squashed ROB entry had a destination.
- `PR_new_flush` input `PR_W`: physical register allocated by the squashed entry.
- `p_rd_new` output `PR_W`: head entry, the next register to allocate.
- `empty` output 1: no free register; the hazard logic stalls dispatch on it.
- `free_cnt` output `PR_W`: number of valid entries, 0..`DEPTH`.
- `overflow` output 1: sticky error flag; a push was dropped because the list was full.

## Operation
- Storage: `DEPTH` entries of `PR_W` bits, plus head pointer, tail pointer, and count.
- pop = `isDispatch && RegDest && !hazard_stall && !recover && !empty`. A pop advances head by 1, modulo `DEPTH`.
- push_r = `retire && RegDest_retire`.
- push_f = `recover && RegDest_ROB`.
- Push order when both pushes occur in one cycle: `PR_old_retire` is written at tail and `PR_new_flush` at tail+1, then tail advances by 2.
- When only one push occurs, its value is written at tail and tail advances by 1.
- All pointer arithmetic wraps modulo `DEPTH`.
- count_next = count − pop + push_r + push_f.
- Capacity rule: pushes are accepted in order (push_r first) while the post-pop count is below `DEPTH`. Any push beyond capacity is dropped, is not written, and sets `overflow`. `overflow` clears only on reset.
- `empty` = (count == 0). There is no bypass: a pop request while empty is ignored even if a push lands in the same cycle.
- Pop and push may occur in the same cycle. When full, a simultaneous pop frees one slot, so one push is accepted with no overflow.
- `p_rd_new` = entry[head] when not empty. Its value is undefined while `empty`, and consumers must not use it then.
- Recovery blocks allocation, but pushes continue normally during recovery.
- No duplicate or range checking is performed on pushed values.

## Timing
- Reset (`rst` = 1 at an edge): entry[i] = `NUM_LR`+i; head = 0; tail = 0; count = `DEPTH`; `overflow` = 0.
- Outputs after reset: `p_rd_new` = 32, `empty` = 0, `free_cnt` = 32, `overflow` = 0.
- Reset overrides all same-cycle pop and push requests. Reset asserted mid-operation restores the full initial list regardless of current contents.
- `p_rd_new`, `empty` and `free_cnt` are combinational from registered state. They are valid in the same cycle the map table consumes `p_rd_new`.
- A pop at edge N makes the next entry visible on `p_rd_new` after edge N.
- A value pushed at edge N can be popped no earlier than the cycle following edge N.
- `overflow` asserts the cycle after the offending edge.

## Test plan
- Reset, then 32 consecutive pops with `isDispatch` = `RegDest` = 1 → `p_rd_new` reads 32, 33, …, 63 in order. After the last pop, `empty` = 1 and `free_cnt` = 0. A 33rd pop request leaves all state unchanged.
- From empty, retire pushes of 5, then 9; then two pops → `p_rd_new` reads 5 then 9, and `empty` returns to 1. Verify head and tail wrap past index 31 across this sequence.
- In one cycle, assert `retire` with `PR_old_retire` = 7 and recovery with `PR_new_flush` = 40 → `free_cnt` increases by 2, and later pops return 7 before 40.
- Gating: `hazard_stall` = 1, `recover` = 1, and `RegDest` = 0 are each applied separately with `isDispatch` = 1 → `p_rd_new` and `free_cnt` are unchanged in each case.
- Overflow: from reset (full), push 3 with no pop → the push is dropped and `overflow` = 1 and remains set. Repeat from full with a simultaneous pop and push → `overflow` stays 0 and the pushed value becomes the tail.
- Mid-operation reset: after 10 pops and 2 pushes, assert `rst` for one cycle → `p_rd_new` = 32, `free_cnt` = 32, `overflow` = 0.
